// File: rtl/cnn_iter_ctrl.sv
// Iteration controller for a 4x4 cellular neural network datapath.
// Sequences INIT, repeated 16-cell sweeps with a LAT-deep writeback pipeline,
// COMMIT at the end of each sweep, and terminates on an iteration limit or
// (optionally) when a whole sweep left every Y output unchanged.
module cnn_iter_ctrl #(
    parameter int LAT    = 1,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              conv_en,
    input  logic              y_changed,
    output logic              busy,
    output logic              load_init,
    output logic              issue,
    output logic [3:0]        cell_idx,
    output logic [8:0]        nbr_mask,
    output logic              wb_en,
    output logic [3:0]        wb_idx,
    output logic              commit,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SWEEP,
        DRAIN,
        COMMIT,
        DONE
    } state_t;

    localparam logic [3:0]        LAST_CELL  = 4'd15;
    localparam logic [3:0]        DRAIN_LAST = 4'(LAT - 1);
    localparam logic [ITER_W-1:0] ITER_ONE   = ITER_W'(1);

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [ITER_W-1:0]          limit_q, limit_d;
    logic                       conv_en_q, conv_en_d;
    logic                       change_q, change_d;
    logic [ITER_W-1:0]          iter_q, iter_d;
    logic                       converged_q, converged_d;
    logic [LAT-1:0]             wb_v_q, wb_v_d;
    logic [LAT-1:0][3:0]        wb_idx_q, wb_idx_d;

    // Outputs decoded directly from the registered state so they are glitch-free
    always_comb begin
        busy      = (state_q != IDLE);
        load_init = (state_q == INIT);
        issue     = (state_q == SWEEP);
        commit    = (state_q == COMMIT);
        done      = (state_q == DONE);
        cell_idx  = issue ? cnt_q : 4'd0;
        converged = converged_q;
        iter_cnt  = iter_q;
        wb_en     = wb_v_q[LAT-1];
        wb_idx    = wb_idx_q[LAT-1];
    end

    // Neighbour validity: border cells see zero padding on the outside edges
    always_comb begin
        nbr_mask = 9'h1FF;
        if (cell_idx[3:2] == 2'd0) begin
            nbr_mask[2:0] = 3'b000;
        end
        if (cell_idx[3:2] == 2'd3) begin
            nbr_mask[8:6] = 3'b000;
        end
        if (cell_idx[1:0] == 2'd0) begin
            nbr_mask[0] = 1'b0;
            nbr_mask[3] = 1'b0;
            nbr_mask[6] = 1'b0;
        end
        if (cell_idx[1:0] == 2'd3) begin
            nbr_mask[2] = 1'b0;
            nbr_mask[5] = 1'b0;
            nbr_mask[8] = 1'b0;
        end
        if (!issue) begin
            nbr_mask = 9'h000;
        end
    end

    // Writeback delay line: issue/cell_idx shifted through LAT stages
    always_comb begin
        wb_v_d      = wb_v_q;
        wb_idx_d    = wb_idx_q;
        wb_v_d[0]   = issue;
        wb_idx_d[0] = cell_idx;
        for (int i = 1; i < LAT; i++) begin
            wb_v_d[i]   = wb_v_q[i-1];
            wb_idx_d[i] = wb_idx_q[i-1];
        end
    end

    // Next-state logic: run sequencing, iteration counting and termination
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        limit_d     = limit_q;
        conv_en_d   = conv_en_q;
        change_d    = change_q;
        iter_d      = iter_q;
        converged_d = converged_q;

        // Writebacks can only occur inside the current sweep/drain window,
        // and the flag is cleared on every sweep entry below.
        if (wb_en && y_changed) begin
            change_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = INIT;
                    limit_d     = (max_iter == '0) ? ITER_ONE : max_iter;
                    conv_en_d   = conv_en;
                    iter_d      = '0;
                    converged_d = 1'b0;
                end
            end
            INIT: begin
                state_d  = SWEEP;
                cnt_d    = 4'd0;
                change_d = 1'b0;
            end
            SWEEP: begin
                if (cnt_q == LAST_CELL) begin
                    state_d = DRAIN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = COMMIT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            COMMIT: begin
                iter_d = iter_q + ITER_ONE;
                if (iter_d == limit_q) begin
                    state_d = DONE;
                end else if (conv_en_q && !change_q) begin
                    state_d     = DONE;
                    converged_d = 1'b1;
                end else begin
                    state_d  = SWEEP;
                    cnt_d    = 4'd0;
                    change_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset also flushes the writeback pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            limit_q     <= '0;
            conv_en_q   <= 1'b0;
            change_q    <= 1'b0;
            iter_q      <= '0;
            converged_q <= 1'b0;
            wb_v_q      <= '0;
            wb_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            limit_q     <= limit_d;
            conv_en_q   <= conv_en_d;
            change_q    <= change_d;
            iter_q      <= iter_d;
            converged_q <= converged_d;
            wb_v_q      <= wb_v_d;
            wb_idx_q    <= wb_idx_d;
        end
    end

endmodule

// File: tb/tb_cnn_iter_ctrl.sv
// Scoreboard bench for cnn_iter_ctrl: each run's expected event schedule is
// derived from the run parameters by arithmetic and queued; a negedge monitor
// pops and compares whenever the DUT presents an event.
module tb_cnn_iter_ctrl;

    localparam int LAT    = 3;
    localparam int ITER_W = 8;
    localparam int PER    = 17 + LAT;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ITER_W-1:0] max_iter;
    logic              conv_en;
    logic              y_changed;
    logic              busy;
    logic              load_init;
    logic              issue;
    logic [3:0]        cell_idx;
    logic [8:0]        nbr_mask;
    logic              wb_en;
    logic [3:0]        wb_idx;
    logic              commit;
    logic              done;
    logic              converged;
    logic [ITER_W-1:0] iter_cnt;

    cnn_iter_ctrl #(.LAT(LAT), .ITER_W(ITER_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .max_iter  (max_iter),
        .conv_en   (conv_en),
        .y_changed (y_changed),
        .busy      (busy),
        .load_init (load_init),
        .issue     (issue),
        .cell_idx  (cell_idx),
        .nbr_mask  (nbr_mask),
        .wb_en     (wb_en),
        .wb_idx    (wb_idx),
        .commit    (commit),
        .done      (done),
        .converged (converged),
        .iter_cnt  (iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int idx;
        int mask;
    } issue_t;

    typedef struct {
        int cyc;
        int iter;
        int conv;
    } done_t;

    issue_t issue_q[$];
    issue_t wb_q[$];
    int     load_q[$];
    issue_t commit_q[$];
    done_t  done_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    int run_s = -10;
    int run_e = -10;
    int held_cyc = -10;
    int held_iter = 0;
    int held_conv = 0;

    // Free-running cycle counter used to timestamp every event
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Geometric neighbour validity: neighbour k sits at (row+k/3-1, col+k%3-1)
    function automatic int refMask(input int idx);
        int m;
        int r;
        int c;
        m = 0;
        for (int k = 0; k < 9; k++) begin
            r = idx / 4 + k / 3 - 1;
            c = idx % 4 + k % 3 - 1;
            if (r >= 0 && r <= 3 && c >= 0 && c <= 3) m |= (1 << k);
        end
        return m;
    endfunction

    // One complete run: predict its schedule, then drive it cycle by cycle
    task automatic applyStimulus(input int mi, input bit ce, input bit noise, input int chg_pct);
        bit     plan[16];
        int     lim;
        int     n;
        int     conv;
        int     s;
        int     t0;
        int     rel;
        int     k;
        int     i;
        issue_t e;
        done_t  d;

        for (int j = 0; j < 16; j++) plan[j] = ($urandom_range(0, 99) < chg_pct);
        lim = (mi == 0) ? 1 : mi;
        n = lim;
        for (int j = 0; j < lim; j++) begin
            if (ce && !plan[j]) begin
                n = j + 1;
                break;
            end
        end
        conv = (ce && !plan[n-1] && n != lim) ? 1 : 0;

        @(posedge clk);
        #1;
        s = cyc;
        load_q.push_back(s + 1);
        for (int it = 0; it < n; it++) begin
            t0 = s + 2 + it * PER;
            for (int c = 0; c < 16; c++) begin
                e.cyc = t0 + c;       e.idx = c; e.mask = refMask(c);
                issue_q.push_back(e);
                e.cyc = t0 + c + LAT; e.mask = 0;
                wb_q.push_back(e);
            end
            e.cyc = t0 + 16 + LAT; e.idx = it; e.mask = 0;
            commit_q.push_back(e);
        end
        d.cyc = s + 2 + n * PER; d.iter = n; d.conv = conv;
        done_q.push_back(d);
        run_s = s;
        run_e = d.cyc;

        start     = 1'b1;
        max_iter  = ITER_W'(mi);
        conv_en   = ce;
        y_changed = $urandom_range(0, 1);

        for (int c = s + 1; c <= d.cyc; c++) begin
            @(posedge clk);
            #1;
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            max_iter  = ITER_W'($urandom_range(0, 255));
            conv_en   = $urandom_range(0, 1);
            y_changed = $urandom_range(0, 1);
            rel = c - (s + 2 + LAT);
            if (rel >= 0) begin
                k = rel / PER;
                i = rel % PER;
                if (k < n && i < 16) begin
                    y_changed = plan[k] ? ((i == 15) || ($urandom_range(0, 3) == 0)) : 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},      busy,      0);
        checkOutput({tag, "_load_init"}, load_init, 0);
        checkOutput({tag, "_issue"},     issue,     0);
        checkOutput({tag, "_cell_idx"},  cell_idx,  0);
        checkOutput({tag, "_nbr_mask"},  nbr_mask,  0);
        checkOutput({tag, "_wb_en"},     wb_en,     0);
        checkOutput({tag, "_wb_idx"},    wb_idx,    0);
        checkOutput({tag, "_commit"},    commit,    0);
        checkOutput({tag, "_done"},      done,      0);
        checkOutput({tag, "_converged"}, converged, 0);
        checkOutput({tag, "_iter_cnt"},  iter_cnt,  0);
    endtask

    // Abort a run in its first sweep at cell 7 with start also high
    task automatic resetMidRun();
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        start     = 1'b1;
        max_iter  = 8'd3;
        conv_en   = 1'b0;
        y_changed = 1'b1;
        repeat (9) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkOutput("pre_rst_issue", issue, 1);
        checkOutput("pre_rst_cell_idx", cell_idx, 7);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("mid_rst");
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_wb_en", wb_en, 0);
            checkOutput("post_rst_busy", busy, 0);
        end
        mon_en = 1'b1;
    endtask

    // Monitor: compares every presented event against the head of its queue
    always @(negedge clk) begin
        issue_t e;
        done_t  d;
        if (mon_en) begin
            checkOutput("busy", busy, (cyc > run_s && cyc <= run_e) ? 1 : 0);
            if (issue) begin
                if (issue_q.size() == 0) checkOutput("issue_unexpected", 1, 0);
                else begin
                    e = issue_q.pop_front();
                    checkOutput("issue_cycle", cyc, e.cyc);
                    checkOutput("cell_idx", cell_idx, e.idx);
                    checkOutput("nbr_mask", nbr_mask, e.mask);
                end
            end else begin
                checkOutput("nbr_mask_idle", nbr_mask, 0);
            end
            if (wb_en) begin
                if (wb_q.size() == 0) checkOutput("wb_unexpected", 1, 0);
                else begin
                    e = wb_q.pop_front();
                    checkOutput("wb_cycle", cyc, e.cyc);
                    checkOutput("wb_idx", wb_idx, e.idx);
                end
            end
            if (load_init) begin
                if (load_q.size() == 0) checkOutput("load_unexpected", 1, 0);
                else checkOutput("load_cycle", cyc, load_q.pop_front());
            end
            if (commit) begin
                if (commit_q.size() == 0) checkOutput("commit_unexpected", 1, 0);
                else begin
                    e = commit_q.pop_front();
                    checkOutput("commit_cycle", cyc, e.cyc);
                    checkOutput("commit_iter_cnt", iter_cnt, e.idx);
                end
            end
            if (done) begin
                if (done_q.size() == 0) checkOutput("done_unexpected", 1, 0);
                else begin
                    d = done_q.pop_front();
                    checkOutput("done_cycle", cyc, d.cyc);
                    checkOutput("done_iter_cnt", iter_cnt, d.iter);
                    checkOutput("done_converged", converged, d.conv);
                    held_cyc  = d.cyc + 1;
                    held_iter = d.iter;
                    held_conv = d.conv;
                end
            end
            if (cyc == held_cyc) begin
                checkOutput("held_iter_cnt", iter_cnt, held_iter);
                checkOutput("held_converged", converged, held_conv);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        max_iter  = '0;
        conv_en   = 1'b0;
        y_changed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst    = 1'b0;
        start  = 1'b0;
        mon_en = 1'b1;

        applyStimulus(2, 1'b0, 1'b0, 0);
        applyStimulus(10, 1'b1, 1'b0, 0);
        applyStimulus(0, 1'b0, 1'b0, 50);
        applyStimulus(0, 1'b1, 1'b0, 0);
        applyStimulus(3, 1'b1, 1'b1, 100);
        for (int r = 0; r < 15; r++) begin
            applyStimulus($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b1,
                          $urandom_range(0, 100));
        end
        resetMidRun();
        applyStimulus(2, 1'b1, 1'b1, 60);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("issue_left",  issue_q.size(),  0);
        checkOutput("wb_left",     wb_q.size(),     0);
        checkOutput("load_left",   load_q.size(),   0);
        checkOutput("commit_left", commit_q.size(), 0);
        checkOutput("done_left",   done_q.size(),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
